// File: rtl/gpio_bank_if.sv
// rtl/gpio_bank_if.sv - register bus bundle for gpio_bank (request and registered response)
interface gpio_bank_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [1:0]            size;
  logic                  we;
  logic                  re;
  logic [31:0]           wd_data;
  logic [31:0]           rd_data;
  logic                  done;
  logic                  check;

  modport master (
    output en, Addr, size, we, re, wd_data,
    input  rd_data, done, check
  );

  modport slave (
    input  en, Addr, size, we, re, wd_data,
    output rd_data, done, check
  );
endinterface

// File: rtl/gpio_bank.sv
// rtl/gpio_bank.sv - register-mapped GPIO bank with per-pin direction and sticky edge interrupts
// Optional interrupt block is built only when GPIO_IRQ_EN is defined.
module gpio_bank #(
  parameter int PIN_COUNT  = 16,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_bank_if.slave           bus,
  input  logic [PIN_COUNT-1:0] GPIO_in,
  output logic [PIN_COUNT-1:0] GPIO_out,
  output logic [PIN_COUNT-1:0] GPIO_oe,
  output logic                 irq
);

  localparam logic [2:0] OFF_DATA_IN    = 3'd0;
  localparam logic [2:0] OFF_DATA_OUT   = 3'd1;
  localparam logic [2:0] OFF_DIR        = 3'd2;
  localparam logic [2:0] OFF_OUT_SET    = 3'd3;
  localparam logic [2:0] OFF_OUT_CLR    = 3'd4;
  localparam logic [2:0] OFF_IRQ_EN     = 3'd5;
  localparam logic [2:0] OFF_IRQ_EDGE   = 3'd6;
  localparam logic [2:0] OFF_IRQ_STATUS = 3'd7;

  logic [PIN_COUNT-1:0] r_data_out;
  logic [PIN_COUNT-1:0] r_dir;
  logic [PIN_COUNT-1:0] r_sync1;
  logic [PIN_COUNT-1:0] r_sync2;
  logic [31:0]          r_rd_data;
  logic                 r_done;
  logic                 r_check;

  logic [31:0]          w_addr;
  logic [2:0]           w_off;
  logic                 w_acc;
  logic                 w_err;
  logic                 w_wr_ok;
  logic                 w_rd_ok;
  logic [PIN_COUNT-1:0] w_wd;
  logic [31:0]          w_rdata;

`ifdef GPIO_IRQ_EN
  logic [PIN_COUNT-1:0] r_irq_en;
  logic [PIN_COUNT-1:0] r_irq_edge;
  logic [PIN_COUNT-1:0] r_irq_status;
  logic [PIN_COUNT-1:0] r_prev;
  logic                 r_irq;
  logic [PIN_COUNT-1:0] w_edge;
  logic [PIN_COUNT-1:0] w_set;
  logic [PIN_COUNT-1:0] w_clr;
`endif

  always_comb begin
    w_addr  = 32'(bus.Addr);
    w_off   = w_addr[4:2];
    w_acc   = bus.en & (bus.we | bus.re);
    w_wd    = bus.wd_data[PIN_COUNT-1:0];
    // Anything outside the word-aligned 0x00..0x1F window is an error, as are the one-way registers.
    w_err   = (w_addr[1:0] != 2'b00) || (bus.size != 2'b10) || (w_addr[31:5] != '0)
           || (bus.we && (w_off == OFF_DATA_IN))
           || (!bus.we && ((w_off == OFF_OUT_SET) || (w_off == OFF_OUT_CLR)));
`ifndef GPIO_IRQ_EN
    w_err   = w_err || (w_off >= OFF_IRQ_EN);
`endif
    w_wr_ok = w_acc & bus.we & ~w_err;
    w_rd_ok = w_acc & ~bus.we & ~w_err;

    w_rdata = '0;
    case (w_off)
      OFF_DATA_IN:    w_rdata[PIN_COUNT-1:0] = r_sync2;
      OFF_DATA_OUT:   w_rdata[PIN_COUNT-1:0] = r_data_out;
      OFF_DIR:        w_rdata[PIN_COUNT-1:0] = r_dir;
`ifdef GPIO_IRQ_EN
      OFF_IRQ_EN:     w_rdata[PIN_COUNT-1:0] = r_irq_en;
      OFF_IRQ_EDGE:   w_rdata[PIN_COUNT-1:0] = r_irq_edge;
      OFF_IRQ_STATUS: w_rdata[PIN_COUNT-1:0] = r_irq_status;
`endif
      default:        w_rdata = '0;
    endcase

`ifdef GPIO_IRQ_EN
    w_edge = (r_irq_edge & r_sync2 & ~r_prev) | (~r_irq_edge & ~r_sync2 & r_prev);
    w_set  = w_edge & ~r_dir;
    w_clr  = (w_wr_ok && (w_off == OFF_IRQ_STATUS)) ? w_wd : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out   <= '0;
      r_dir        <= '0;
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_rd_data    <= '0;
      r_done       <= 1'b0;
      r_check      <= 1'b0;
`ifdef GPIO_IRQ_EN
      r_irq_en     <= '0;
      r_irq_edge   <= '0;
      r_irq_status <= '0;
      r_prev       <= '0;
      r_irq        <= 1'b0;
`endif
    end else begin
      r_sync1   <= GPIO_in;
      r_sync2   <= r_sync1;
      r_done    <= w_acc;
      r_check   <= w_acc & w_err;
      r_rd_data <= w_rd_ok ? w_rdata : '0;

      if (w_wr_ok) begin
        case (w_off)
          OFF_DATA_OUT: r_data_out <= w_wd;
          OFF_DIR:      r_dir      <= w_wd;
          OFF_OUT_SET:  r_data_out <= r_data_out | w_wd;
          OFF_OUT_CLR:  r_data_out <= r_data_out & ~w_wd;
`ifdef GPIO_IRQ_EN
          OFF_IRQ_EN:   r_irq_en   <= w_wd;
          OFF_IRQ_EDGE: r_irq_edge <= w_wd;
`endif
          default: ;
        endcase
      end

`ifdef GPIO_IRQ_EN
      r_prev       <= r_sync2;
      // A new edge outranks a same-cycle write-1-to-clear so no event is lost.
      r_irq_status <= (r_irq_status & ~w_clr) | w_set;
      r_irq        <= |(r_irq_status & r_irq_en);
`endif
    end
  end

  assign bus.rd_data = r_rd_data;
  assign bus.done    = r_done;
  assign bus.check   = r_check;
  assign GPIO_out    = r_data_out;
  assign GPIO_oe     = r_dir;
`ifdef GPIO_IRQ_EN
  assign irq         = r_irq;
`else
  assign irq         = 1'b0;
`endif

endmodule
